// File: rtl/fir_tap_load_ctrl.sv
// Coefficient load sequencer for a two-stage tiny_fir interpolator chain.
// Streams taps from one shared BROM into each FIR in turn, waits for each
// stage's load-complete, then holds both FIRs enabled and releases the
// sample path via load_done.
module fir_tap_load_ctrl #(
    parameter int unsigned G_TAP_RES     = 16,
    parameter int unsigned G_ADDR_WIDTH  = 7,
    parameter int unsigned G_NUM_TAPS_S0 = 63,
    parameter int unsigned G_NUM_TAPS_S1 = 31,
    parameter int unsigned G_TIMEOUT     = 255
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    reload,
    output logic [G_ADDR_WIDTH-1:0] rom_addr,
    output logic                    rom_rd,
    input  logic [G_TAP_RES-1:0]    rom_data,
    input  logic                    rom_data_valid,
    output logic [1:0]              fir_enable,
    output logic [1:0]              tap_wr,
    output logic [G_TAP_RES-1:0]    tap_val,
    input  logic [1:0]              tap_wr_done,
    output logic                    load_done,
    output logic                    load_err
);

    localparam int unsigned AW = G_ADDR_WIDTH;
    localparam int unsigned TW = $clog2(G_TIMEOUT + 1);

    localparam logic [AW-1:0] NUM_S0   = AW'(G_NUM_TAPS_S0);
    localparam logic [AW-1:0] NUM_S1   = AW'(G_NUM_TAPS_S1);
    localparam logic [AW-1:0] BASE_S1  = AW'(G_NUM_TAPS_S0);
    localparam logic [TW-1:0] TMO_LAST = TW'(G_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_S0 = 3'd1,
        WAIT_S0 = 3'd2,
        LOAD_S1 = 3'd3,
        WAIT_S1 = 3'd4,
        RUN     = 3'd5
    } state_t;

    state_t        state;
    logic [AW-1:0] tap_cnt;     // reads issued in the current stage
    logic [TW-1:0] tmo_cnt;     // cycles spent waiting for tap_wr_done
    logic          rd_stage;    // stage owning the read currently on rom_rd
    logic          rd_pend;     // a read is in flight inside the BROM
    logic          pend_stage;  // stage owning the in-flight read
    logic          stall;       // timeout seen; blocks restart until enable drops

    // Load sequencer: state, BROM read issue, FIR enables and status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            tap_cnt    <= '0;
            tmo_cnt    <= '0;
            rd_stage   <= 1'b0;
            stall      <= 1'b0;
            rom_addr   <= '0;
            rom_rd     <= 1'b0;
            fir_enable <= 2'b00;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else if (!enable) begin
            state      <= IDLE;
            tap_cnt    <= '0;
            tmo_cnt    <= '0;
            rd_stage   <= 1'b0;
            stall      <= 1'b0;
            rom_addr   <= '0;
            rom_rd     <= 1'b0;
            fir_enable <= 2'b00;
            load_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rom_rd     <= 1'b0;
                    rom_addr   <= '0;
                    fir_enable <= 2'b00;
                    load_done  <= 1'b0;
                    if (!stall) begin
                        state      <= LOAD_S0;
                        rom_rd     <= 1'b1;
                        rom_addr   <= '0;
                        rd_stage   <= 1'b0;
                        tap_cnt    <= AW'(1);
                        fir_enable <= 2'b01;
                        load_err   <= 1'b0;
                    end
                end
                LOAD_S0: begin
                    if (tap_cnt == NUM_S0) begin
                        state    <= WAIT_S0;
                        rom_rd   <= 1'b0;
                        rom_addr <= '0;
                        tmo_cnt  <= '0;
                    end else begin
                        rom_rd   <= 1'b1;
                        rom_addr <= tap_cnt;
                        tap_cnt  <= tap_cnt + AW'(1);
                    end
                end
                WAIT_S0: begin
                    if (tap_wr_done[0]) begin
                        state      <= LOAD_S1;
                        rom_rd     <= 1'b1;
                        rom_addr   <= BASE_S1;
                        rd_stage   <= 1'b1;
                        tap_cnt    <= AW'(1);
                        fir_enable <= 2'b11;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state      <= IDLE;
                        fir_enable <= 2'b00;
                        load_err   <= 1'b1;
                        stall      <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                LOAD_S1: begin
                    if (tap_cnt == NUM_S1) begin
                        state    <= WAIT_S1;
                        rom_rd   <= 1'b0;
                        rom_addr <= '0;
                        tmo_cnt  <= '0;
                    end else begin
                        rom_rd   <= 1'b1;
                        rom_addr <= BASE_S1 + tap_cnt;
                        tap_cnt  <= tap_cnt + AW'(1);
                    end
                end
                WAIT_S1: begin
                    if (tap_wr_done[1]) begin
                        state      <= RUN;
                        fir_enable <= 2'b11;
                        load_done  <= 1'b1;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state      <= IDLE;
                        fir_enable <= 2'b00;
                        load_err   <= 1'b1;
                        stall      <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                RUN: begin
                    // Passing through IDLE gives the one-cycle FIR reset pulse
                    if (reload) begin
                        state      <= IDLE;
                        fir_enable <= 2'b00;
                        load_done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Tap forwarding: returned BROM words go to the stage that issued the read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend    <= 1'b0;
            pend_stage <= 1'b0;
            tap_wr     <= 2'b00;
            tap_val    <= '0;
        end else if (!enable) begin
            rd_pend    <= 1'b0;
            pend_stage <= 1'b0;
            tap_wr     <= 2'b00;
            tap_val    <= '0;
        end else begin
            rd_pend    <= rom_rd;
            pend_stage <= rd_stage;
            if (rom_data_valid && rd_pend) begin
                tap_wr  <= pend_stage ? 2'b10 : 2'b01;
                tap_val <= rom_data;
            end else begin
                tap_wr  <= 2'b00;
                tap_val <= '0;
            end
        end
    end

endmodule

// File: doc/fir_tap_load_ctrl.md
# fir_tap_load_ctrl

Sequences coefficient loading for a two-stage tiny_fir interpolator chain (e.g. 4x stage then 2x stage) from one shared single-port tap BROM. After enable, or on a reload request, the block brings each FIR out of reset in turn and streams its taps into it. It waits for that FIR's tap_wr_done, then releases the sample path. The block sits beside the upsampler datapath and replaces per-stage free-running BROM address counters.

## Interface
- G_TAP_RES, 16, tap word width
- G_ADDR_WIDTH, 7, BROM address width
- G_NUM_TAPS_S0, 63, stage-0 tap count (BROM addresses 0..G_NUM_TAPS_S0-1)
- G_NUM_TAPS_S1, 31, stage-1 tap count (BROM addresses G_NUM_TAPS_S0..G_NUM_TAPS_S0+G_NUM_TAPS_S1-1)
- G_TIMEOUT, 255, max cycles to wait for tap_wr_done after the last tap of a stage
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  synchronous block enable; low forces IDLE
- reload  in  1  single-cycle pulse; re-loads both stages from RUN
- rom_addr  out  G_ADDR_WIDTH  BROM address
- rom_rd  out  1  BROM read strobe
- rom_data  in  G_TAP_RES  BROM data; valid exactly 1 cycle after rom_rd
- rom_data_valid  in  1  BROM data qualifier
- fir_enable  out  2  per-stage FIR enable (bit s drives stage s)
- tap_wr  out  2  per-stage tap write strobe, one-hot or zero
- tap_val  out  G_TAP_RES  tap value, shared by both stages
- tap_wr_done  in  2  per-stage load-complete from each FIR
- load_done  out  1  both stages loaded; gates upstream din_valid/din_ready
- load_err  out  1  sticky timeout flag; cleared on entry to LOAD_S0

## Operation
- States: IDLE, LOAD_S0, WAIT_S0, LOAD_S1, WAIT_S1, RUN.
- IDLE: all outputs 0. Go to LOAD_S0 when enable=1.
- LOAD_Ss:
  - fir_enable[s] and all lower bits are 1.
  - rom_rd=1 on G_NUM_TAPS_Ss consecutive cycles, with rom_addr stepping by 1 from the stage base.
  - After the last read, go to WAIT_Ss.
- Tap forwarding:
  - Each rom_data_valid produces tap_wr[s]=1 and tap_val=rom_data, registered one cycle later.
  - s is the stage latched when the read was issued, so pipelined reads crossing a state change still land on the correct stage.
  - tap_wr pulse count per stage equals G_NUM_TAPS_Ss exactly.
- WAIT_Ss:
  - Timeout counter starts at 0.
  - tap_wr_done[s]=1 moves to LOAD_S1 (s=0) or RUN (s=1).
  - If the counter reaches G_TIMEOUT without done: set load_err, drive fir_enable=0, go to IDLE.
  - While load_err=1, IDLE does not restart. Leave it by toggling enable low, or via reset.
- RUN: fir_enable=2'b11, load_done=1.
- reload in RUN:
  - Next cycle: fir_enable=0 and load_done=0 for exactly one cycle. This resets both FIRs.
  - Then LOAD_S0.
  - reload in any other state is ignored.
- enable=0 in any state: next cycle IDLE, all outputs 0 except load_err. Any pending forwarded tap is discarded.
- Counters: tap counter is G_ADDR_WIDTH bits; timeout counter is clog2(G_TIMEOUT+1) bits. No wrap is possible within a stage.

## Timing
- Async reset: every output and internal register goes to 0 immediately; state=IDLE.
- Edge numbering: the first edge with enable=1 in IDLE is edge 0, which enters LOAD_S0.
  - rom_rd=1 on edges 1..63 with rom_addr 0..62.
  - tap_wr[0] is high on edges 3..65 (rom_rd -> rom_data_valid 1 cycle, plus 1 register stage).
- Stage transition: WAIT_S0 begins at edge 64. The earliest LOAD_S1 begins 1 cycle after tap_wr_done[0] is sampled high.
- Throughput: no bubbles within a stage; one BROM read per cycle.
- Outputs: all are registered; no combinational input-to-output path.

## Test plan
- Defaults, enable rises, both FIRs return done 2 cycles after their last tap_wr -> 63 tap_wr[0] pulses carrying BROM[0..62] in order, then 31 tap_wr[1] pulses carrying BROM[63..93]. load_done=1, fir_enable=2'b11, load_err=0.
- tap_wr_done[1] held low -> WAIT_S1 exits after exactly 255 cycles. load_err=1, fir_enable=0, and the block stays in IDLE. Toggle enable 0 then 1 -> reload succeeds and load_err clears at LOAD_S0 entry.
- reload pulse in RUN -> fir_enable=0 for 1 cycle, then the full load repeats with identical tap_wr data. reload pulses during LOAD_S0 or WAIT_S1 have no effect.
- enable dropped on the 10th tap_wr[0] -> next cycle all outputs 0 and no further tap_wr. Re-enable -> load restarts at rom_addr 0 with 63 pulses.
- reset_n asserted mid-LOAD_S1, asynchronously between edges -> outputs 0 before the next edge. Release -> idle until enable; load_err=0.
- G_NUM_TAPS_S0=1, G_NUM_TAPS_S1=1 -> exactly one tap_wr per stage at addresses 0 and 1, and no extra rom_rd.
